// File: rtl/ctech_lib_cdc_tx_pkg.sv
// Shared types and default parameter values for the bundled-data CDC
// handshake transmitter.
package ctech_lib_cdc_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_t;

  localparam int unsigned CDC_TX_WIDTH_DEF   = 8;
  localparam int unsigned CDC_TX_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/ctech_lib_doublesync_rstb.sv
// Library double-flop synchronizer with synchronous active-low reset.
// The input may be asynchronous to clk; the output is settled after two edges.
module ctech_lib_doublesync_rstb #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next-state: shift the async input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ctech_lib_cdc_handshake_tx.sv
// Source-side transmitter of a bundled-data req/ack CDC handshake.
// Supports 2-phase (toggle) and 4-phase (return-to-zero) signalling.
// Optional watchdog: define CTECH_LIB_CDC_TX_TIMEOUT_EN to build the
// timeout counter and sticky timeout_err flag; otherwise timeout_err is 0.
module ctech_lib_cdc_handshake_tx
  import ctech_lib_cdc_tx_pkg::*;
#(
  parameter int unsigned WIDTH          = CDC_TX_WIDTH_DEF,
  parameter bit          FOUR_PHASE     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = CDC_TX_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx_req,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ack,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  // Reject nonsensical configurations at elaboration.
  if (WIDTH < 1 || TIMEOUT_CYCLES < 4) begin : g_bad_param
    $error("ctech_lib_cdc_handshake_tx: WIDTH must be >=1, TIMEOUT_CYCLES >=4");
  end

  state_t           state_q, state_d;
  logic             tx_req_q, tx_req_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             done_q, done_d;
  logic             ack_sync;
  logic             accept;

  ctech_lib_doublesync_rstb #(
    .WIDTH (1)
  ) u_ack_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (tx_ack),
    .q    (ack_sync)
  );

  // Ready only when idle and the previous handshake has fully returned;
  // derived from registers so it never depends on in_valid.
  assign in_ready = (state_q == IDLE) && (ack_sync == tx_req_q);
  assign accept   = in_valid && in_ready;

  // Handshake FSM next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d = in_data;
          if (FOUR_PHASE) begin
            tx_req_d = 1'b1;
            state_d  = REQ_HI;
          end else begin
            tx_req_d = ~tx_req_q;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (ack_sync == tx_req_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      REQ_HI: begin
        if (ack_sync) begin
          tx_req_d = 1'b0;
          state_d  = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and launch registers; data is held stable while not idle.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

`ifdef CTECH_LIB_CDC_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Watchdog: count cycles spent in a non-idle state, restart on every
  // state change; the error flag is sticky and never aborts the handshake.
  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if (state_q != IDLE && wd_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
    if (state_q != IDLE && wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      timeout_err_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
